// File: rtl/dmem_if.sv
// Data-bus handshake bundle between the core (master) and the data memory responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request in flight, programmable wait latency,
// single response beat carrying load data and an access-fault flag.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // 33 bits so the span compare cannot overflow for very large memories.
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Contents are not reset; a store that reached its commit edge survives rst.
    logic [31:0] mem [DEPTH_WORDS];

    logic             commit;
    logic             mem_we;
    logic             acc_write;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_be;
    logic [31:0]      acc_off;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;

    // Ready comes from registered state only; held low while reset is asserted.
    assign bus.req_ready = (state_q == StIdle) && !rst;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // Select the access operands: live request for a zero-latency commit in IDLE, else latched copy.
    always_comb begin
        acc_write = write_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state_q == StIdle) begin
            acc_write = bus.req_write;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
        end
        // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
        acc_off = acc_addr - BASE_ADDR;
        acc_err = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_off} >= SPAN_BYTES);
        acc_idx = acc_off[IDX_W+1:2];
    end

    // Next-state, wait counter and response register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        commit  = 1'b1;
                        state_d = StResp;
                    end else begin
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (commit) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
        end
    end

    assign mem_we = commit && acc_write && !acc_err && !rst;

    // Control and response registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture the request at acceptance; the initiator may change req_* afterwards.
    always_ff @(posedge clk) begin
        if (state_q == StIdle && bus.req_valid) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end
    end

    // Byte-lane store at the commit edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance driven through a response queue
// and a LATENCY=0 instance checked for its two-cycle accept/respond rhythm.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_if bus ();
    dmem_if bus0 ();

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (32'h0000_0000),
        .LATENCY    (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (32'h0000_0000),
        .LATENCY    (0)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    // Monitor: every completed response beat is compared with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
                check({e.tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
            end
        end
    end

    task automatic issue(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input bit expect_rsp, input bit chk_lat);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            check({tag, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        if (expect_rsp) begin
            e.tag   = tag;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        // Scramble the request after acceptance; the DUT must use its latched copy.
        bus.req_valid = 1'b0;
        bus.req_write = ~wr;
        bus.req_addr  = 32'hFFFF_FFF1;
        bus.req_wdata = ~wdata;
        bus.req_be    = ~be;
        if (chk_lat) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.rsp_valid && n < 50);
            check({tag, "_latency"}, 32'(n), 32'd3);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !bus.req_ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            check("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err);
        issue(tag, wr, addr, wdata, be, exp_rdata, exp_err, 1'b1, 1'b1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rr[10];
        logic rv[10];
        int   acc;

        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_be     = 4'd0;
        bus.rsp_ready  = 1'b1;
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'b0;
        bus0.req_addr  = 32'd0;
        bus0.req_wdata = 32'd0;
        bus0.req_be    = 4'd0;
        bus0.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_req_ready_lat0", 32'(bus0.req_ready), 32'd1);

        // Basic store / load.
        txn("st_10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
        txn("ld_10", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte lanes, including an all-disabled no-op store.
        txn("st_20_pre", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'd0, 1'b0);
        txn("st_20_be5", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0);
        txn("ld_20", 1'b0, 32'h20, 32'd0, 4'hF, 32'h11BB_33DD, 1'b0);
        txn("st_20_be0", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0);
        txn("ld_20_again", 1'b0, 32'h20, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0);

        // Faults and range edges.
        txn("ld_22_misal", 1'b0, 32'h22, 32'd0, 4'hF, 32'd0, 1'b1);
        txn("st_00", 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0);
        txn("st_1000_oob", 1'b1, 32'h1000, 32'h5555_5555, 4'hF, 32'd0, 1'b1);
        txn("ld_00", 1'b0, 32'h0, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0);
        txn("ld_top_oob", 1'b0, 32'hFFFF_FFFC, 32'd0, 4'h0, 32'd0, 1'b1);
        txn("st_ffc", 1'b1, 32'hFFC, 32'h0BAD_CAFE, 4'hF, 32'd0, 1'b0);
        txn("ld_ffc", 1'b0, 32'hFFC, 32'd0, 4'h0, 32'h0BAD_CAFE, 1'b0);

        // Response backpressure with a competing request that must not be taken.
        bus.rsp_ready = 1'b0;
        issue("ld_bp", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0;
        bus.req_be    = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
        check("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        txn("ld_10_after_bp", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);

        // Reset while holding a load response: outputs drop at once.
        bus.rsp_ready = 1'b0;
        issue("ld_rst_resp", 1'b0, 32'h10, 32'd0, 4'h0, 32'd0, 1'b0, 1'b0, 1'b1);
        check("resp_before_rst_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        #1;
        rst = 1'b1;
        #1;
        check("rst_in_resp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_in_resp_rdata", bus.rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset after a store has committed: the write persists.
        issue("st_34_commit", 1'b1, 32'h34, 32'hFEED_FACE, 4'hF, 32'd0, 1'b0, 1'b0, 1'b1);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        txn("ld_34", 1'b0, 32'h34, 32'd0, 4'h0, 32'hFEED_FACE, 1'b0);

        // Reset during WAIT: the store is discarded.
        txn("st_30_zero", 1'b1, 32'h30, 32'h0, 4'hF, 32'd0, 1'b0);
        issue("st_30_abort", 1'b1, 32'h30, 32'h1234_5678, 4'hF, 32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_in_wait_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_in_wait_err", 32'(bus.rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_wait_req_ready", 32'(bus.req_ready), 32'd1);
        txn("ld_30", 1'b0, 32'h30, 32'd0, 4'h0, 32'd0, 1'b0);

        // Zero-latency instance: continuous requests alternate accept / respond.
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b1;
        bus0.req_write = 1'b1;
        bus0.req_addr  = 32'h40;
        bus0.req_wdata = 32'h0A0B_0C0D;
        bus0.req_be    = 4'hF;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rr[i] = bus0.req_ready;
            rv[i] = bus0.rsp_valid;
            if (rr[i]) acc++;
            if (rv[i]) check("lat0_store_rdata", bus0.rsp_rdata, 32'd0);
        end
        check("lat0_accept_count", 32'(acc), 32'd5);
        check("lat0_first_ready", 32'(rr[0]), 32'd1);
        for (int i = 1; i < 10; i++) begin
            check("lat0_rsp_follows_accept", 32'(rv[i]), 32'(rr[i-1]));
            check("lat0_alternate", 32'(rr[i]), 32'(!rr[i-1]));
        end
        @(posedge clk);
        #1;
        bus0.req_write = 1'b0;
        @(negedge clk);
        check("lat0_ld_ready", 32'(bus0.req_ready), 32'd1);
        @(negedge clk);
        check("lat0_ld_valid", 32'(bus0.rsp_valid), 32'd1);
        check("lat0_ld_rdata", bus0.rsp_rdata, 32'h0A0B_0C0D);
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        repeat (2) @(posedge clk);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
